// File: rtl/ldpc_vfu_pkg.sv
// ldpc_vfu_pkg: shared FSM state type, message saturation and default sizes for the VFU controller
package ldpc_vfu_pkg;
  localparam int N_COL_DEF = 533;
  localparam int DV_DEF = 5;
  localparam int MW_DEF = 4;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} vfu_state_t;
  // clamp v to the signed range of an mw-bit message
  function automatic int sat_msg(input int v, input int mw);
    int hi;
    hi = (1 << (mw - 1)) - 1;
    return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
  endfunction
endpackage

// File: rtl/vfu_ctrl_param_vn_core.sv
// vn_core_param: combinational variable-node update (total, extrinsic vn_i, hard bit)
//   cn   : DV packed CN->VN messages, slot i at [i*MW +: MW]
//   org  : channel LLR
//   vn   : DV packed saturated VN->CN messages
//   hard : sign of the full-width total (1 = negative)
module vn_core_param
  import ldpc_vfu_pkg::*;
#(
  parameter int DV = DV_DEF,
  parameter int MW = MW_DEF
) (
  input  logic [DV*MW-1:0] cn,
  input  logic [MW-1:0]    org,
  output logic [DV*MW-1:0] vn,
  output logic             hard
);
  localparam int TW = MW + $clog2(DV + 1);
  logic signed [TW-1:0] total;
  int s;
  always_comb begin
    s = 0;
    vn = '0;
    total = TW'($signed(org));
    for (int i = 0; i < DV; i++) total = total + TW'($signed(cn[i*MW +: MW]));
    for (int i = 0; i < DV; i++) begin
      s = sat_msg(int'(total) - int'($signed(cn[i*MW +: MW])), MW);
      vn[i*MW +: MW] = s[MW-1:0];
    end
  end
  assign hard = total[TW-1];
endmodule

// File: rtl/vfu_ctrl_param.sv
// vfu_ctrl_param: parametrised LDPC variable-node update sweep controller
//   sys_clk, sys_rst_n (async, active-low)
//   flag_VFU_start / flag_frame_new : start or restart a sweep, optionally clearing hard decisions
//   stall                           : freezes FSM, address and accumulators; suppresses strobes
//   ram_VFU_data, org_data          : CN messages and channel LLR of the current column
//   VFU_addr, VFU_data, VFU_re_en, VFU_wr_en : CN-message RAM port
//   bit_data_reg, flag_VFU_end, busy         : sweep results and status
//   hd_change_cnt, hd_unchanged     : hard-decision change tracking, built only with VFU_HD_CHANGE_EN
module vfu_ctrl_param
  import ldpc_vfu_pkg::*;
#(
  parameter int N_COL = N_COL_DEF,
  parameter int DV = DV_DEF,
  parameter int MW = MW_DEF,
  parameter int AW = $clog2(N_COL)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             flag_VFU_start,
  input  logic             flag_frame_new,
  input  logic             stall,
  input  logic [DV*MW-1:0] ram_VFU_data,
  input  logic [MW-1:0]    org_data,
  output logic [AW-1:0]    VFU_addr,
  output logic [DV*MW-1:0] VFU_data,
  output logic             VFU_re_en,
  output logic             VFU_wr_en,
  output logic [N_COL-1:0] bit_data_reg,
  output logic             flag_VFU_end,
  output logic             busy,
  output logic [AW:0]      hd_change_cnt,
  output logic             hd_unchanged
);
  vfu_state_t state;
  logic [N_COL-1:0] sr;
  logic hard;
  logic last;
  logic wr_fire;
  logic done_upd;
  vn_core_param #(.DV(DV), .MW(MW)) u_core (
    .cn(ram_VFU_data),
    .org(org_data),
    .vn(VFU_data),
    .hard(hard)
  );
  assign last = VFU_addr == AW'(N_COL - 1);
  assign wr_fire = state == WRITE && !stall && !flag_VFU_start;
  // a start landing in DONE still commits the finished sweep
  assign done_upd = state == DONE && (!stall || flag_VFU_start);
  assign VFU_re_en = state == READ && !stall;
  assign VFU_wr_en = state == WRITE && !stall;
  assign flag_VFU_end = state == DONE;
  assign busy = state != IDLE;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      VFU_addr <= '0;
      sr <= '0;
      bit_data_reg <= '0;
    end else begin
      state <= flag_VFU_start ? READ : stall ? state :
               state == READ ? WRITE : state == WRITE ? (last ? DONE : READ) : IDLE;
      VFU_addr <= flag_VFU_start ? '0 : (wr_fire && !last) ? VFU_addr + AW'(1) : VFU_addr;
      sr <= flag_VFU_start ? '0 : wr_fire ? {hard, sr[N_COL-1:1]} : sr;
      bit_data_reg <= (flag_VFU_start && flag_frame_new) ? '0 : done_upd ? sr : bit_data_reg;
    end
`ifdef VFU_HD_CHANGE_EN
  logic [AW:0] cnt;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      cnt <= '0;
      hd_change_cnt <= '0;
      hd_unchanged <= 1'b0;
    end else begin
      cnt <= flag_VFU_start ? '0 : wr_fire ? cnt + (AW+1)'(hard ^ bit_data_reg[VFU_addr]) : cnt;
      hd_change_cnt <= done_upd ? cnt : hd_change_cnt;
      hd_unchanged <= done_upd ? cnt == '0 : hd_unchanged;
    end
`else
  assign hd_change_cnt = '0;
  assign hd_unchanged = 1'b0;
`endif
endmodule

// File: doc/vfu_ctrl_param.md
# vfu_ctrl_param

Parametrised variable-node update (VFU) controller for the LDPC decoder. It replaces the fixed 533-column, degree-5 controller with one configurable in column count, VN degree and message width. It adds a stall handshake, a saturating VN core, and hard-decision change tracking for early termination. It sits between the CN-message RAM (read/write via `VFU_addr`) and the iteration controller, which consumes `flag_VFU_end`, `bit_data_reg` and `hd_unchanged`.

## Interface
- `N_COL`, 533, number of variable nodes (columns) per sweep; ≥2.
- `DV`, 5, VN degree (CN messages per column); 2..8.
- `MW`, 4, message width, two's complement.
- `AW`, $clog2(N_COL), address width.
- `sys_clk` in 1: clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `flag_VFU_start` in 1: one-cycle pulse; starts or restarts a sweep.
- `flag_frame_new` in 1: sampled with start; 1 clears `bit_data_reg` (new codeword).
- `stall` in 1: 1 freezes the FSM and suppresses strobes.
- `ram_VFU_data` in DV*MW: CN→VN messages; slot i at [i*MW +: MW].
- `org_data` in MW: channel LLR for the current column.
- `VFU_addr` out AW: column address.
- `VFU_data` out DV*MW: VN→CN messages, same slot packing.
- `VFU_re_en` / `VFU_wr_en` out 1: RAM read / write strobes.
- `bit_data_reg` out N_COL: hard decisions from the last completed sweep; column k at bit k.
- `flag_VFU_end` out 1: one-cycle sweep-complete pulse.
- `busy` out 1: sweep in progress.
- `hd_change_cnt` out AW+1: number of columns whose hard bit differed from the previous sweep.
- `hd_unchanged` out 1: `hd_change_cnt`==0 at the last completed sweep.

## Operation
- FSM states: IDLE, READ, WRITE, DONE. Reset to IDLE.
- Transitions:
  - IDLE→READ on start; `VFU_addr`←0.
  - READ→WRITE.
  - WRITE→READ with `VFU_addr`+1 if `VFU_addr`<N_COL-1; otherwise WRITE→DONE.
  - DONE→IDLE.
- Stall: with `stall`=1, the state, address and all accumulators hold. The RAM keeps its output because no new read is issued.
- Strobes: `VFU_re_en`=(READ & !stall); `VFU_wr_en`=(WRITE & !stall). Both are combinational from state.
- VN arithmetic:
  - `total` = `org_data` + Σ cn_i, sign-extended to MW+$clog2(DV+1) bits; no overflow is possible.
  - vn_i = sat_MW(`total` − cn_i), clamped to [−2^(MW-1), 2^(MW-1)−1].
  - Hard bit = sign of the full-width `total` (1 = negative).
- Hard decisions: on each non-stalled WRITE cycle, the hard bit is shifted in at the MSB of an internal N_COL shift register. After N_COL writes, column k sits at bit k.
- Change count: on each non-stalled WRITE, the counter increments if the new hard bit ≠ `bit_data_reg[VFU_addr]` (the previous sweep's bit).
- Start while busy: aborts, `VFU_addr`←0, FSM→READ, shift register and counter cleared; `bit_data_reg` is untouched unless `flag_frame_new`=1.
- Start together with `flag_frame_new`: `bit_data_reg`←0 in the same cycle.

## Timing
- Reset values:
  - `VFU_addr`=0, `bit_data_reg`=0, `hd_change_cnt`=0.
  - `flag_VFU_end`=0, `busy`=0, `hd_unchanged`=0.
  - strobes 0, `VFU_data` = function of inputs.
- Start pulse at cycle t → READ at t+1 (`VFU_re_en`=1, addr 0).
- RAM read latency is 1; `ram_VFU_data` is valid during WRITE.
- `VFU_data` is combinational from RAM data in WRITE and is written at the same address.
- Sweep length without stall: 2·N_COL cycles plus 1 DONE cycle; `flag_VFU_end` is high during DONE.
- In DONE:
  - `bit_data_reg`, `hd_change_cnt` and `hd_unchanged` update on the DONE clock edge and are visible the cycle after `flag_VFU_end`.
  - `busy` is high from READ through DONE inclusive.
- Start in the DONE cycle: end still pulses, registers update, then a new sweep starts at READ.
- Reset mid-sweep: all registers return to reset values immediately.

## Configuration
- `VFU_HD_CHANGE_EN` defined: change counter, comparison logic and `hd_unchanged` are built as described.
- Not defined: `hd_change_cnt` is tied to 0 and `hd_unchanged` to 0. The iteration controller must then run the maximum iteration count. No change-tracking flops are synthesised.

## Structure
- Package `ldpc_vfu_pkg`:
  - state enum (IDLE/READ/WRITE/DONE);
  - saturation function `sat_msg`;
  - default N_COL/DV/MW constants.
- One sub-module, `vn_core_param`: purely combinational `total`/vn_i/hard-bit computation, parametrised by DV and MW. The controller owns all sequential logic.

## Test plan
- N_COL=8, DV=5, MW=4; start, org=+3, all cn=+1 → `total`=8, vn_i=7, hard bit 0; `bit_data_reg`=0x00; end at cycle 17 after start.
- org=−8, all cn=−8 → `total`=−48; vn_i saturate to −8; hard bit 1; column 3 alone negative → `bit_data_reg`=0x08.
- Two sweeps, second flipping columns 0 and 5 → `hd_change_cnt`=2, `hd_unchanged`=0; a third identical sweep → 0 and 1.
- `stall` held 3 cycles in WRITE at addr 4 → no strobes during stall, addr stays 4, sweep ends 3 cycles late with identical results.
- Start reasserted at addr 5, then start with `flag_frame_new` → restart at addr 0; `bit_data_reg` cleared only in the second case.
- `sys_rst_n` low mid-sweep → all outputs at reset values; no `flag_VFU_end` pulse.
